// File: rtl/lsu_bus_ctrl_if.sv
// Core-side request/response handshake plus the single-beat memory bus of the LSU.
// The controller takes the master modport; the core/memory environment takes slave.
interface lsu_bus_ctrl_if #(
    parameter int XLEN = 32
);
    localparam int NB = XLEN / 8;

    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_is_load;
    logic [2:0]      req_is_store;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic [1:0]      resp_err;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [NB-1:0]   mem_wmask;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        input  req_valid, req_is_load, req_is_store, req_addr, req_wdata,
        input  resp_ready, mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport slave (
        output req_valid, req_is_load, req_is_store, req_addr, req_wdata,
        output resp_ready, mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: classifies one core access, runs it on the memory bus
// with a timeout, and returns extended load data or an error code.
module lsu_bus_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    lsu_bus_ctrl_if.master    bus
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CNTW = 16;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_MIS = 2'b01;
    localparam logic [1:0] ERR_ILL = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic                op_load_q;
    logic [2:0]          ld_type_q;
    logic [OFFW-1:0]     off_q;
    logic [CNTW-1:0]     cnt_q;
    logic                mem_we_q;
    logic [XLEN-1:0]     mem_addr_q;
    logic [XLEN-1:0]     mem_wdata_q;
    logic [NB-1:0]       mem_wmask_q;
    logic [XLEN-1:0]     resp_rdata_q;
    logic [1:0]          resp_err_q;

    logic                is_ld, is_st, illegal, misalign, tmo_hit;
    logic [1:0]          sz;
    logic [OFFW-1:0]     off;
    logic                resp_set;
    logic [1:0]          resp_err_d;
    logic [XLEN-1:0]     resp_rdata_d;
    logic [XLEN-1:0]     done_data;

    function automatic logic [NB-1:0] size_mask(input logic [1:0] s);
        logic [NB-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++)
            if (i < (1 << s)) m[i] = 1'b1;
        return m;
    endfunction

    // The addressed lane is shifted down to bit 0 before extension.
    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] t,
                                                    input logic [XLEN-1:0] word,
                                                    input logic [OFFW-1:0] o);
        logic [XLEN-1:0] lane;
        lane = word >> {o, 3'b000};
        case (t)
            3'b000:  return XLEN'($signed(lane[7:0]));
            3'b001:  return XLEN'($signed(lane[15:0]));
            3'b010:  return XLEN'($signed(lane[31:0]));
            3'b100:  return XLEN'(lane[7:0]);
            3'b101:  return XLEN'(lane[15:0]);
            3'b110:  return XLEN'(lane[31:0]);
            default: return lane;
        endcase
    endfunction

    assign is_ld = (bus.req_is_load  != 3'b111);
    assign is_st = (bus.req_is_store != 3'b111);
    assign sz    = is_ld ? bus.req_is_load[1:0] : bus.req_is_store[1:0];
    assign off   = bus.req_addr[OFFW-1:0];

    always_comb begin
        illegal = (is_ld == is_st);
        if (is_ld && XLEN == 32 && (bus.req_is_load == 3'b011 || bus.req_is_load == 3'b110))
            illegal = 1'b1;
        if (is_st && (bus.req_is_store[2] || (XLEN == 32 && bus.req_is_store == 3'b011)))
            illegal = 1'b1;
    end

    always_comb begin
        case (sz)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = bus.req_addr[0];
            2'b10:   misalign = |bus.req_addr[1:0];
            default: misalign = |bus.req_addr[2:0];
        endcase
    end

    assign tmo_hit   = (cnt_q == CNTW'(TIMEOUT - 1));
    assign done_data = op_load_q ? load_extend(ld_type_q, bus.mem_rdata, off_q) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Completion is checked before timeout so data arriving on the last cycle still wins.
    always_comb begin
        state_d      = state_q;
        resp_set     = 1'b0;
        resp_err_d   = ERR_OK;
        resp_rdata_d = '0;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                if (illegal) begin
                    state_d = RESP; resp_set = 1'b1; resp_err_d = ERR_ILL;
                end else if (misalign) begin
                    state_d = RESP; resp_set = 1'b1; resp_err_d = ERR_MIS;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: if (bus.mem_gnt && bus.mem_rvalid) begin
                state_d = RESP; resp_set = 1'b1; resp_rdata_d = done_data;
            end else if (tmo_hit) begin
                state_d = RESP; resp_set = 1'b1; resp_err_d = ERR_TMO;
            end else if (bus.mem_gnt) begin
                state_d = WAIT;
            end
            WAIT: if (bus.mem_rvalid) begin
                state_d = RESP; resp_set = 1'b1; resp_rdata_d = done_data;
            end else if (tmo_hit) begin
                state_d = RESP; resp_set = 1'b1; resp_err_d = ERR_TMO;
            end
            RESP: if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_load_q    <= 1'b0;
            ld_type_q    <= 3'b111;
            off_q        <= '0;
            cnt_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= ERR_OK;
        end else begin
            if (state_q == IDLE && bus.req_valid) begin
                op_load_q <= is_ld;
                ld_type_q <= bus.req_is_load;
                off_q     <= off;
                if (!illegal && !misalign) begin
                    mem_we_q    <= is_st;
                    mem_addr_q  <= {bus.req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                    mem_wdata_q <= is_st ? (bus.req_wdata << {off, 3'b000}) : '0;
                    mem_wmask_q <= is_st ? (size_mask(sz) << off) : '0;
                end
            end
            if (state_q == IDLE)
                cnt_q <= '0;
            else if (state_q == REQ || state_q == WAIT)
                cnt_q <= cnt_q + 1'b1;
            if (resp_set) begin
                resp_rdata_q <= resp_rdata_d;
                resp_err_q   <= resp_err_d;
            end
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_req    = (state_q == REQ);
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wmask  = mem_wmask_q;
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed scoreboard bench for lsu_bus_ctrl: a 32-bit instance (TIMEOUT=4) and a
// 64-bit instance, each with a response monitor popping hand-computed expectations.
module tb_lsu_bus_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lsu_bus_ctrl_if #(.XLEN(32)) b32 ();
    lsu_bus_ctrl_if #(.XLEN(64)) b64 ();

    lsu_bus_ctrl #(.XLEN(32), .TIMEOUT(4)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    lsu_bus_ctrl #(.XLEN(64), .TIMEOUT(4)) dut64 (.clk(clk), .rst(rst), .bus(b64));

    typedef struct {
        logic [63:0] rdata;
        logic [1:0]  err;
        string       name;
    } exp_t;

    typedef struct {
        logic [2:0]  ld;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] maddr;
        logic [31:0] exp;
        string       name;
    } ld_vec_t;

    typedef struct {
        logic [2:0]  ld;
        logic [2:0]  st;
        logic [31:0] addr;
        logic [1:0]  err;
        string       name;
    } err_vec_t;

    exp_t q32[$];
    exp_t q64[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic exp32(input logic [63:0] rdata, input logic [1:0] err, input string name);
        exp_t e;
        e.rdata = rdata; e.err = err; e.name = name;
        q32.push_back(e);
    endtask

    task automatic exp64(input logic [63:0] rdata, input logic [1:0] err, input string name);
        exp_t e;
        e.rdata = rdata; e.err = err; e.name = name;
        q64.push_back(e);
    endtask

    // Called just after a rising edge with the DUT idle; returns just after the accept edge.
    task automatic issue32(input logic [2:0] ld, input logic [2:0] st,
                           input logic [31:0] addr, input logic [31:0] wdata);
        b32.req_is_load = ld; b32.req_is_store = st;
        b32.req_addr = addr;  b32.req_wdata = wdata;
        b32.req_valid = 1'b1;
        @(posedge clk); #1;
        b32.req_valid = 1'b0;
    endtask

    task automatic issue64(input logic [2:0] ld, input logic [2:0] st,
                           input logic [63:0] addr, input logic [63:0] wdata);
        b64.req_is_load = ld; b64.req_is_store = st;
        b64.req_addr = addr;  b64.req_wdata = wdata;
        b64.req_valid = 1'b1;
        @(posedge clk); #1;
        b64.req_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (b32.resp_valid && b32.resp_ready) begin
            if (q32.size() == 0) begin
                total_cnt++;
                $display("FAIL resp32_unexpected: got response err=%0d rdata=0x%0h, expected none",
                         b32.resp_err, b32.resp_rdata);
            end else begin
                e = q32.pop_front();
                chk({e.name, "_rdata"}, 64'(b32.resp_rdata), e.rdata);
                chk({e.name, "_err"},   64'(b32.resp_err),   64'(e.err));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b64.resp_valid && b64.resp_ready) begin
            if (q64.size() == 0) begin
                total_cnt++;
                $display("FAIL resp64_unexpected: got response err=%0d rdata=0x%0h, expected none",
                         b64.resp_err, b64.resp_rdata);
            end else begin
                e = q64.pop_front();
                chk({e.name, "_rdata"}, b64.resp_rdata,     e.rdata);
                chk({e.name, "_err"},   64'(b64.resp_err),  64'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    ld_vec_t  lv[5];
    err_vec_t ev[8];

    initial begin
        lv[0] = '{3'b000, 32'h8000_0003, 32'h80FF_1234, 32'h8000_0000, 32'hFFFF_FF80, "lb_sext"};
        lv[1] = '{3'b010, 32'h0000_0020, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, "lw_after_tmo"};
        lv[2] = '{3'b101, 32'h0000_0002, 32'h8001_0000, 32'h0000_0000, 32'h0000_8001, "lhu_zext"};
        lv[3] = '{3'b001, 32'h0000_0002, 32'h8001_0000, 32'h0000_0000, 32'hFFFF_8001, "lh_sext"};
        lv[4] = '{3'b100, 32'h0000_0001, 32'h0000_A500, 32'h0000_0000, 32'h0000_00A5, "lbu_zext"};
        ev[0] = '{3'b010, 3'b111, 32'h101, 2'b01, "lw_misalign"};
        ev[1] = '{3'b011, 3'b111, 32'h000, 2'b10, "ld_on_rv32"};
        ev[2] = '{3'b111, 3'b111, 32'h000, 2'b10, "no_op"};
        ev[3] = '{3'b000, 3'b000, 32'h000, 2'b10, "load_and_store"};
        ev[4] = '{3'b111, 3'b100, 32'h000, 2'b10, "store_1xx"};
        ev[5] = '{3'b001, 3'b111, 32'h001, 2'b01, "lh_misalign"};
        ev[6] = '{3'b111, 3'b011, 32'h000, 2'b10, "sd_on_rv32"};
        ev[7] = '{3'b110, 3'b111, 32'h000, 2'b10, "lwu_on_rv32"};

        b32.req_valid = 0; b32.req_is_load = 3'b111; b32.req_is_store = 3'b111;
        b32.req_addr = 0;  b32.req_wdata = 0; b32.resp_ready = 1;
        b32.mem_gnt = 0;   b32.mem_rvalid = 0; b32.mem_rdata = 0;
        b64.req_valid = 0; b64.req_is_load = 3'b111; b64.req_is_store = 3'b111;
        b64.req_addr = 0;  b64.req_wdata = 0; b64.resp_ready = 1;
        b64.mem_gnt = 0;   b64.mem_rvalid = 0; b64.mem_rdata = 0;

        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 64'(b32.resp_valid), 0);
        chk("rst_mem_req",    64'(b32.mem_req),    0);
        chk("rst_mem_we",     64'(b32.mem_we),     0);
        chk("rst_mem_addr",   64'(b32.mem_addr),   0);
        chk("rst_mem_wmask",  64'(b32.mem_wmask),  0);
        chk("rst_resp_err",   64'(b32.resp_err),   0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 64'(b32.req_ready), 1);
        @(posedge clk); #1;

        // Halfword store: lane shift and byte enables held while waiting for grant.
        exp32(0, 2'b00, "sh_resp");
        issue32(3'b111, 3'b001, 32'h102, 32'h0000_ABCD);
        @(negedge clk);
        chk("sh_mem_req",   64'(b32.mem_req),   1);
        chk("sh_mem_addr",  64'(b32.mem_addr),  64'h100);
        chk("sh_mem_wmask", 64'(b32.mem_wmask), 64'hC);
        chk("sh_mem_wdata", 64'(b32.mem_wdata), 64'hABCD_0000);
        chk("sh_mem_we",    64'(b32.mem_we),    1);
        @(negedge clk);
        chk("sh_hold_req",  64'(b32.mem_req),   1);
        chk("sh_hold_addr", 64'(b32.mem_addr),  64'h100);
        b32.mem_gnt = 1; b32.mem_rvalid = 1;
        @(posedge clk); #1;
        b32.mem_gnt = 0; b32.mem_rvalid = 0;
        @(posedge clk); #1;

        foreach (ev[i]) begin
            exp32(0, ev[i].err, ev[i].name);
            issue32(ev[i].ld, ev[i].st, ev[i].addr, 0);
            @(negedge clk);
            chk({ev[i].name, "_no_mem_req"}, 64'(b32.mem_req),    0);
            chk({ev[i].name, "_lat1"},       64'(b32.resp_valid), 1);
            @(posedge clk); #1;
        end

        // Grant without completion: timeout fires 4 cycles after entering REQ.
        b32.mem_gnt = 1; b32.mem_rvalid = 0;
        exp32(0, 2'b11, "timeout");
        issue32(3'b010, 3'b111, 32'h10, 0);
        @(negedge clk);
        chk("tmo_mem_req", 64'(b32.mem_req), 1);
        @(posedge clk); #1;
        b32.mem_gnt = 0;
        @(negedge clk);
        chk("tmo_wait_no_req", 64'(b32.mem_req), 0);
        @(negedge clk);
        @(negedge clk);
        chk("tmo_not_early", 64'(b32.resp_valid), 0);
        @(negedge clk);
        chk("tmo_at_4", 64'(b32.resp_valid), 1);
        b32.mem_rvalid = 1; b32.mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        b32.mem_rvalid = 0;
        @(negedge clk);
        chk("late_rvalid_ignored", 64'(b32.resp_valid), 0);
        @(posedge clk); #1;

        // Loads with grant and data in the same cycle: two-cycle latency.
        foreach (lv[i]) begin
            b32.mem_gnt = 1; b32.mem_rvalid = 1; b32.mem_rdata = lv[i].rdata;
            exp32(64'(lv[i].exp), 2'b00, lv[i].name);
            issue32(lv[i].ld, 3'b111, lv[i].addr, 0);
            @(negedge clk);
            chk({lv[i].name, "_mem_req"},   64'(b32.mem_req),    1);
            chk({lv[i].name, "_mem_addr"},  64'(b32.mem_addr),   64'(lv[i].maddr));
            chk({lv[i].name, "_mem_wmask"}, 64'(b32.mem_wmask),  0);
            chk({lv[i].name, "_lat_lo"},    64'(b32.resp_valid), 0);
            @(negedge clk);
            chk({lv[i].name, "_lat2"},      64'(b32.resp_valid), 1);
            @(posedge clk); #1;
            b32.mem_gnt = 0; b32.mem_rvalid = 0;
        end

        // Reset in WAIT drops the access; nothing may be reported afterwards.
        b32.mem_gnt = 1;
        issue32(3'b010, 3'b111, 32'h40, 0);
        @(posedge clk); #1;
        b32.mem_gnt = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_mem_req",    64'(b32.mem_req),    0);
        chk("arst_mem_addr",   64'(b32.mem_addr),   0);
        chk("arst_resp_valid", 64'(b32.resp_valid), 0);
        chk("arst_resp_rdata", 64'(b32.resp_rdata), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        b32.mem_rvalid = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("arst_no_resp", 64'(b32.resp_valid), 0);
        end
        chk("arst_req_ready", 64'(b32.req_ready), 1);
        b32.mem_rvalid = 0;
        @(posedge clk); #1;

        // 64-bit doubleword store.
        exp64(0, 2'b00, "sd64_resp");
        issue64(3'b111, 3'b011, 64'h8, 64'h1122_3344_5566_7788);
        @(negedge clk);
        chk("sd64_mem_addr",  b64.mem_addr,       64'h8);
        chk("sd64_mem_wmask", 64'(b64.mem_wmask), 64'hFF);
        chk("sd64_mem_wdata", b64.mem_wdata,      64'h1122_3344_5566_7788);
        chk("sd64_mem_we",    64'(b64.mem_we),    1);
        b64.mem_gnt = 1; b64.mem_rvalid = 1;
        @(negedge clk);
        b64.mem_gnt = 0; b64.mem_rvalid = 0;
        @(posedge clk); #1;

        // LWU from upper word, response back-pressured for 3 cycles.
        b64.mem_gnt = 1; b64.mem_rvalid = 1; b64.mem_rdata = 64'hF000_0001_0000_0000;
        b64.resp_ready = 0;
        exp64(64'h0000_0000_F000_0001, 2'b00, "lwu64");
        issue64(3'b110, 3'b111, 64'h4, 0);
        @(posedge clk); #1;
        b64.mem_gnt = 0; b64.mem_rvalid = 0; b64.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lwu64_hold_valid", 64'(b64.resp_valid), 1);
            chk("lwu64_hold_rdata", b64.resp_rdata,      64'h0000_0000_F000_0001);
            chk("lwu64_hold_err",   64'(b64.resp_err),   0);
        end
        @(posedge clk); #1;
        b64.resp_ready = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        exp64(0, 2'b01, "ld64_misalign");
        issue64(3'b011, 3'b111, 64'h4, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        #1;
        chk("q32_drained", 64'(q32.size()), 0);
        chk("q64_drained", 64'(q64.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
